// File: rtl/ram2p_16384x16.sv
// Dual-port synchronous program RAM, 16384x16, shared clock, registered read data on both ports.
// Optional address range checker and out-of-array suppression: define RAM2P_RANGE_CHECK_EN.
module ram2p_16384x16 #(
    parameter int unsigned DEPTH  = 16384,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned MAX_A  = 16383,
    parameter int unsigned MAX_B  = 16384
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    output logic [DATA_W-1:0] q_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    output logic [DATA_W-1:0] q_b,
    output logic              fire_a,
    output logic              fire_b,
    output logic              err_sticky
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [IdxW-1:0]   idx_a;
    logic [IdxW-1:0]   idx_b;
    logic              in_a;
    logic              in_b;
    logic [DATA_W-1:0] q_a_q, q_a_d;
    logic [DATA_W-1:0] q_b_q, q_b_d;

    assign idx_a = address_a[IdxW-1:0];
    assign idx_b = address_b[IdxW-1:0];

`ifdef RAM2P_RANGE_CHECK_EN
    logic fire_a_q, fire_a_d;
    logic fire_b_q, fire_b_d;
    logic sticky_q, sticky_d;

    assign in_a = 32'(address_a) < DEPTH;
    assign in_b = 32'(address_b) < DEPTH;

    always_comb begin
        fire_a_d = 32'(address_a) > MAX_A;
        fire_b_d = 32'(address_b) > MAX_B;
        // Sticky follows the fire inputs so it rises in the same cycle as fire_x.
        sticky_d = sticky_q | fire_a_d | fire_b_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fire_a_q <= 1'b0;
            fire_b_q <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            fire_a_q <= fire_a_d;
            fire_b_q <= fire_b_d;
            sticky_q <= sticky_d;
        end
    end

    assign fire_a     = fire_a_q;
    assign fire_b     = fire_b_q;
    assign err_sticky = sticky_q;
`else
    // Upper address bits alias onto the array when the checker is absent.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{address_a[ADDR_W-1:IdxW], address_b[ADDR_W-1:IdxW]};

    assign in_a       = 1'b1;
    assign in_b       = 1'b1;
    assign fire_a     = 1'b0;
    assign fire_b     = 1'b0;
    assign err_sticky = 1'b0;
`endif

    // Port A write is issued last so it wins a same-index collision.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (wren_b && in_b) mem_q[idx_b] <= data_b;
            if (wren_a && in_a) mem_q[idx_a] <= data_a;
        end
    end

    always_comb begin
        q_a_d = q_a_q;
        q_b_d = q_b_q;
        if (!wren_a) q_a_d = in_a ? mem_q[idx_a] : '0;
        if (!wren_b) q_b_d = in_b ? mem_q[idx_b] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_a_q <= '0;
            q_b_q <= '0;
        end else begin
            q_a_q <= q_a_d;
            q_b_q <= q_b_d;
        end
    end

    assign q_a = q_a_q;
    assign q_b = q_b_q;

endmodule

// File: tb/tb_ram2p_16384x16.sv
// Self-checking bench for ram2p_16384x16: directed cases plus random traffic against an array model.
module tb_ram2p_16384x16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] address_a = '0, address_b = '0;
    logic [15:0] data_a = '0, data_b = '0;
    logic        wren_a = 1'b0, wren_b = 1'b0;
    logic [15:0] q_a, q_b;
    logic        fire_a, fire_b, err_sticky;

    int total = 0;
    int bad   = 0;

    // Reference model: only words the bench has written are known.
    logic [15:0] mdl [int];
    logic [15:0] exp_qa = '0, exp_qb = '0;
    bit          kn_qa = 1'b1, kn_qb = 1'b1;
    bit          exp_fa = 1'b0, exp_fb = 1'b0, exp_st = 1'b0;

`ifdef RAM2P_RANGE_CHECK_EN
    localparam bit ChkEn = 1'b1;
`else
    localparam bit ChkEn = 1'b0;
`endif

    ram2p_16384x16 dut (
        .clock(clock), .reset(reset),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .q_a(q_a),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .q_b(q_b),
        .fire_a(fire_a), .fire_b(fire_b), .err_sticky(err_sticky)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_arr(input logic [15:0] a);
        return !ChkEn || (a < 16'd16384);
    endfunction

    function automatic int idx(input logic [15:0] a);
        return int'(a) % 16384;
    endfunction

    task automatic check_all();
        chk("fire_a", 16'(fire_a), 16'(exp_fa));
        chk("fire_b", 16'(fire_b), 16'(exp_fb));
        chk("err_sticky", 16'(err_sticky), 16'(exp_st));
        if (kn_qa) chk("q_a", q_a, exp_qa);
        if (kn_qb) chk("q_b", q_b, exp_qb);
    endtask

    // One clock: drive, advance, then update model from the pre-edge contents and compare.
    task automatic step(input bit wa, input logic [15:0] aa, input logic [15:0] da,
                        input bit wb, input logic [15:0] ab, input logic [15:0] db);
        wren_a = wa; address_a = aa; data_a = da;
        wren_b = wb; address_b = ab; data_b = db;
        @(posedge clock);
        #1;
        exp_fa = ChkEn && (aa > 16'd16383);
        exp_fb = ChkEn && (int'(ab) > 16384);
        exp_st = exp_st | exp_fa | exp_fb;
        if (!wa) begin
            if (!in_arr(aa)) begin exp_qa = '0; kn_qa = 1'b1; end
            else if (mdl.exists(idx(aa))) begin exp_qa = mdl[idx(aa)]; kn_qa = 1'b1; end
            else kn_qa = 1'b0;
        end
        if (!wb) begin
            if (!in_arr(ab)) begin exp_qb = '0; kn_qb = 1'b1; end
            else if (mdl.exists(idx(ab))) begin exp_qb = mdl[idx(ab)]; kn_qb = 1'b1; end
            else kn_qb = 1'b0;
        end
        if (wb && in_arr(ab)) mdl[idx(ab)] = db;
        if (wa && in_arr(aa)) mdl[idx(aa)] = da;
        check_all();
    endtask

    // Reset cycle with write enables high: writes must be suppressed.
    task automatic do_reset();
        reset = 1'b1;
        wren_a = 1'b1; address_a = 16'h0005; data_a = 16'hFFFF;
        wren_b = 1'b1; address_b = 16'h0006; data_b = 16'hFFFF;
        @(posedge clock);
        #1;
        reset = 1'b0;
        wren_a = 1'b0; wren_b = 1'b0;
        exp_qa = '0; exp_qb = '0; kn_qa = 1'b1; kn_qb = 1'b1;
        exp_fa = 1'b0; exp_fb = 1'b0; exp_st = 1'b0;
        check_all();
    endtask

    function automatic logic [15:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 16'h3FF0 + 16'($urandom_range(0, 15));
            1:       return 16'h3FFC + 16'($urandom_range(0, 8));
            2:       return 16'($urandom);
            default: return 16'($urandom_range(0, 15));
        endcase
    endfunction

    initial begin
        do_reset();
        step(0, 16'h0000, 16'h0, 0, 16'h0000, 16'h0);

        // Seed the working windows so later reads are predictable.
        for (int i = 0; i < 16; i++)
            step(1, 16'(i), 16'($urandom), 1, 16'h3FF0 + 16'(i), 16'($urandom));
        step(1, 16'h0010, 16'h1111, 0, 16'h0000, 16'h0);
        do_reset();
        // Reset must not have written 0xFFFF at 5/6.
        step(0, 16'h0005, 16'h0, 0, 16'h0006, 16'h0);

        // B fetches what A just wrote.
        step(1, 16'h0123, 16'hBEEF, 0, 16'h0000, 16'h0);
        step(0, 16'h0000, 16'h0, 0, 16'h0123, 16'h0);
        chk("fetch_beef", q_b, 16'hBEEF);

        // Write-cycle hold and mixed-port read-during-write.
        step(0, 16'h0010, 16'h0, 0, 16'h0000, 16'h0);
        chk("rd_1111", q_a, 16'h1111);
        step(1, 16'h0010, 16'h2222, 0, 16'h0010, 16'h0);
        chk("hold_qa", q_a, 16'h1111);
        chk("rdw_old", q_b, 16'h1111);
        step(0, 16'h0010, 16'h0, 0, 16'h0000, 16'h0);
        chk("rd_2222", q_a, 16'h2222);

        // Collision: A wins.
        step(1, 16'h3FFF, 16'hAAAA, 1, 16'h3FFF, 16'h5555);
        step(0, 16'h3FFF, 16'h0, 0, 16'h3FFF, 16'h0);
        chk("collide_a", q_a, 16'hAAAA);
        chk("collide_b", q_b, 16'hAAAA);

        if (ChkEn) begin
            step(1, 16'h4000, 16'hDEAD, 0, 16'h0000, 16'h0);
            chk("oob_fire_a", 16'(fire_a), 16'd1);
            chk("oob_sticky", 16'(err_sticky), 16'd1);
            step(0, 16'h0000, 16'h0, 0, 16'h4000, 16'h0);
            chk("limit_fire_b", 16'(fire_b), 16'd0);
            chk("oob_rd_zero", q_b, 16'h0000);
            chk("sticky_hold", 16'(err_sticky), 16'd1);
            step(0, 16'h0000, 16'h0, 0, 16'h4001, 16'h0);
            chk("over_fire_b", 16'(fire_b), 16'd1);
            do_reset();
            chk("sticky_clr", 16'(err_sticky), 16'd0);
        end else begin
            step(1, 16'h4005, 16'h1234, 0, 16'h0000, 16'h0);
            step(0, 16'h0000, 16'h0, 0, 16'h0005, 16'h0);
            chk("alias_rd", q_b, 16'h1234);
            chk("alias_fire", 16'({fire_a, fire_b, err_sticky}), 16'd0);
        end

        for (int n = 0; n < 400; n++) begin
            if (n == 200) do_reset();
            step(bit'($urandom_range(0, 2) == 0), pick_addr(), 16'($urandom),
                 bit'($urandom_range(0, 2) == 0), pick_addr(), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram2p_16384x16.md
# ram2p_16384x16

Dual-port synchronous program-memory RAM: 16384 words of 16 bits, one shared clock, two independent read/write ports with registered outputs. Port A serves the debug/loader read-write path; port B serves the core instruction fetch. An optional address range checker flags out-of-range accesses.

## Interface
- `DEPTH`, 16384: number of words in the array; power of two.
- `DATA_W`, 16: word width.
- `ADDR_W`, 16: input address width; must be ≥ log2(`DEPTH`).
- `MAX_A`, 16383: highest legal port-A address for range checking.
- `MAX_B`, 16384: highest legal port-B address for range checking; one past the end, so prefetch is legal.

Ports:
- `clock`, in, 1: the single clock; all logic on its rising edge.
- `reset`, in, 1: reset is synchronous and active-high.
- `address_a`, in, `ADDR_W`: port-A word address.
- `data_a`, in, `DATA_W`: port-A write data.
- `wren_a`, in, 1: port-A write enable.
- `q_a`, out, `DATA_W`: port-A registered read data.
- `address_b`, in, `ADDR_W`: port-B word address.
- `data_b`, in, `DATA_W`: port-B write data.
- `wren_b`, in, 1: port-B write enable.
- `q_b`, out, `DATA_W`: port-B registered read data.
- `fire_a`, out, 1: port-A range violation, registered.
- `fire_b`, out, 1: port-B range violation, registered.
- `err_sticky`, out, 1: latched OR of `fire_a` and `fire_b`.

## Operation
- Storage is an array of `DEPTH` × `DATA_W`. Contents are undefined at power-up and are not cleared by `reset`.
- Index is the low log2(`DEPTH`) bits of the address; the "in-array" condition is address < `DEPTH`.
- Port write: when `wren_x`=1 and `reset`=0, `data_x` is written at the index.
  - `q_x` holds its previous value in a write cycle; the write port never reads.
- Port read: when `wren_x`=0 and `reset`=0, `q_x` loads the word at the index.
- Both ports write the same index in the same cycle: port A's data is stored.
- Mixed-port read-during-write (one port reads the index the other port writes): the reader gets the old data.
- Range check (macro enabled):
  - `fire_a` = (`address_a` > `MAX_A`), sampled every non-reset cycle.
  - `fire_b` = (`address_b` > `MAX_B`), sampled every non-reset cycle.
  - `err_sticky` sets when either fire asserts and clears only on `reset`.
- Out-of-array accesses (address ≥ `DEPTH`, macro enabled): the write is dropped and a read returns 0.
- Reset cycle:
  - `q_a`, `q_b`, `fire_a`, `fire_b` and `err_sticky` go to 0.
  - Writes are suppressed.

## Timing
- Read latency is 1 cycle: address at edge N gives data on `q_x` after edge N+1.
- A write is visible to a read on either port issued on the following edge.
- `fire_x` asserts one cycle after the offending address. `err_sticky` asserts in the same cycle as `fire_x` and stays high.
- Reset values: every output is 0.
- No handshake; both ports are always ready, every cycle.

## Configuration
- `RAM2P_RANGE_CHECK_EN` defined:
  - Range checker and out-of-array suppression are built as described above.
- `RAM2P_RANGE_CHECK_EN` undefined:
  - `fire_a`, `fire_b` and `err_sticky` are tied to 0.
  - Upper address bits are ignored, so an address aliases onto index (address mod `DEPTH`) for both reads and writes.

## Test plan
- Reset then idle: outputs sampled after the reset cycle → `q_a`=`q_b`=0 and `fire_a`=`fire_b`=`err_sticky`=0.
- Port-B fetch of a port-A write: A writes 0xBEEF at address 0x0123; next cycle B reads 0x0123 → `q_b`=0xBEEF one cycle later.
- Write-cycle hold and read-during-write:
  - A reads 0x0010, which holds 0x1111.
  - Next cycle A writes 0x2222 to 0x0010 while B reads 0x0010 → `q_a` stays 0x1111 and `q_b`=0x1111 (old data).
  - Following read of 0x0010 → 0x2222.
- Write collision: A writes 0xAAAA and B writes 0x5555, both at 0x3FFF → a read of 0x3FFF returns 0xAAAA.
- Range check enabled:
  - `address_a`=0x4000 with `wren_a`=1 → `fire_a`=1 next cycle and `err_sticky`=1 persists; index 0x0000 is unchanged.
  - `address_b`=0x4000 → `fire_b`=0 (legal limit); `q_b` reads 0.
  - `reset` → `err_sticky`=0.
- Range check disabled: A writes 0x1234 at 0x4005; B reads 0x0005 → `q_b`=0x1234, and the fire outputs stay 0.
